// File: rtl/pipe_sched_pkg.sv
// Shared pipeline-scheduler types: FSM state encoding and mult/div latency defaults.
// The latency defaults are also consumed by the mult/div datapath unit.
package pipe_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } sched_state_e;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 8;

  // Countdown preload: the issue cycle itself counts toward the total latency.
  function automatic logic [7:0] md_load(input logic is_div, input int mult_cyc, input int div_cyc);
    return is_div ? 8'(div_cyc - 1) : 8'(mult_cyc - 1);
  endfunction

endpackage

// File: rtl/pipe_sched_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// One-cycle update latency; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_sched.sv
// Pipeline stall/flush scheduler: merges branch, load-use and mult/div occupancy into stage enables.
// Control outputs are same-cycle combinational; only fsm, md_cnt and stall_cnt are registered.
module pipe_sched
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hz_stall,
  input  logic             branch_taken,
  input  logic             id_md_req,
  input  logic             id_md_div,
  input  logic             id_hilo_rd,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             md_go,
  output logic             md_busy,
  output logic             hilo_we,
  output logic [CNT_W-1:0] stall_cnt
);

  sched_state_e fsm;
  logic [7:0]   md_cnt;

  logic in_wait;
  logic md_done;
  logic struct_stall;
  logic stall;
  logic issue;

  always_comb begin
    in_wait      = (fsm == ST_MD_WAIT);
    md_done      = in_wait && (md_cnt == 8'd1);
    // HI/LO readers and a second mult/div must wait for the unit, including its final cycle.
    struct_stall = in_wait && (id_hilo_rd || id_md_req);
    stall        = !branch_taken && (hz_stall || struct_stall);
    issue        = !in_wait && id_md_req && !branch_taken && !hz_stall;
  end

  // Reset forces a flushed, frozen pipeline regardless of the inputs.
  always_comb begin
    pc_en       = reset_n && !stall;
    if_id_en    = reset_n && !stall;
    if_id_flush = !reset_n || branch_taken;
    id_ex_flush = !reset_n || branch_taken || stall;
    md_go       = reset_n && issue;
    md_busy     = reset_n && in_wait;
    hilo_we     = reset_n && md_done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm    <= ST_RUN;
      md_cnt <= 8'd0;
    end else begin
      case (fsm)
        ST_RUN: begin
          if (issue) begin
            md_cnt <= md_load(id_md_div, MULT_CYCLES, DIV_CYCLES);
            fsm    <= ST_MD_WAIT;
          end
        end
        ST_MD_WAIT: begin
          if (md_cnt == 8'd1) begin
            md_cnt <= 8'd0;
            fsm    <= ST_RUN;
          end else begin
            md_cnt <= md_cnt - 8'd1;
          end
        end
        default: begin
          fsm    <= ST_RUN;
          md_cnt <= 8'd0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (!pc_en),
    .q     (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_sched.sv
// Directed self-checking bench for pipe_sched with hand-computed control vectors.
module tb_pipe_sched;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic             hz_stall;
  logic             branch_taken;
  logic             id_md_req;
  logic             id_md_div;
  logic             id_hilo_rd;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             md_go;
  logic             md_busy;
  logic             hilo_we;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk;
  int n_err;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, md_go, md_busy, hilo_we}
  logic [6:0] ctl;
  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_flush, md_go, md_busy, hilo_we};

  localparam logic [6:0] C_RST     = 7'b0011000;
  localparam logic [6:0] C_IDLE    = 7'b1100000;
  localparam logic [6:0] C_GO      = 7'b1100100;
  localparam logic [6:0] C_BUSY    = 7'b1100010;
  localparam logic [6:0] C_DONE    = 7'b1100011;
  localparam logic [6:0] C_SSTALL  = 7'b0001010;
  localparam logic [6:0] C_SDONE   = 7'b0001011;
  localparam logic [6:0] C_HZ      = 7'b0001000;
  localparam logic [6:0] C_BR      = 7'b1111000;
  localparam logic [6:0] C_BR_BUSY = 7'b1111010;

  pipe_sched #(
    .MULT_CYCLES(4),
    .DIV_CYCLES (8),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hz_stall    (hz_stall),
    .branch_taken(branch_taken),
    .id_md_req   (id_md_req),
    .id_md_div   (id_md_div),
    .id_hilo_rd  (id_hilo_rd),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .md_go       (md_go),
    .md_busy     (md_busy),
    .hilo_we     (hilo_we),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs are sampled 1 ns later.
  task automatic step(input logic hz, input logic br, input logic req, input logic dv, input logic hrd);
    @(negedge clk);
    hz_stall     = hz;
    branch_taken = br;
    id_md_req    = req;
    id_md_div    = dv;
    id_hilo_rd   = hrd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    hz_stall     = 1'b0;
    branch_taken = 1'b0;
    id_md_req    = 1'b0;
    id_md_div    = 1'b0;
    id_hilo_rd   = 1'b0;
    #1;
    check("rst_ctl", 32'(ctl), 32'(C_RST));
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_chk        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    hz_stall     = 1'b0;
    branch_taken = 1'b0;
    id_md_req    = 1'b0;
    id_md_div    = 1'b0;
    id_hilo_rd   = 1'b0;

    // Reset in the middle of a div: outputs collapse at once, no late hilo_we.
    do_reset();
    step(0, 0, 0, 0, 0);
    check("post_rst_idle", 32'(ctl), 32'(C_IDLE));
    step(0, 0, 1, 1, 0);
    check("div_go", 32'(ctl), 32'(C_GO));
    step(0, 0, 0, 0, 0);
    check("div_busy1", 32'(ctl), 32'(C_BUSY));
    step(0, 0, 0, 0, 0);
    check("div_busy2", 32'(ctl), 32'(C_BUSY));
    #1;
    reset_n = 1'b0;
    #1;
    check("midop_rst_ctl", 32'(ctl), 32'(C_RST));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      check($sformatf("abandon_idle%0d", i), 32'(ctl), 32'(C_IDLE));
    end
    check("abandon_cnt", 32'(stall_cnt), 32'd0);

    // Mult: busy 3 cycles, hilo_we 3 cycles after md_go, no stall.
    do_reset();
    step(0, 0, 1, 0, 0);
    check("mul_go", 32'(ctl), 32'(C_GO));
    step(0, 0, 0, 0, 0);
    check("mul_busy1", 32'(ctl), 32'(C_BUSY));
    step(0, 0, 0, 0, 0);
    check("mul_busy2", 32'(ctl), 32'(C_BUSY));
    step(0, 0, 0, 0, 0);
    check("mul_done", 32'(ctl), 32'(C_DONE));
    step(0, 0, 0, 0, 0);
    check("mul_after", 32'(ctl), 32'(C_IDLE));
    check("mul_cnt", 32'(stall_cnt), 32'd0);

    // mfhi right behind a div: 7 stall cycles, released the cycle after hilo_we.
    do_reset();
    step(0, 0, 1, 1, 0);
    check("mfhi_go", 32'(ctl), 32'(C_GO));
    for (int i = 1; i <= 7; i++) begin
      step(0, 0, 0, 0, 1);
      check($sformatf("mfhi_stall%0d", i), 32'(ctl), 32'(i == 7 ? C_SDONE : C_SSTALL));
    end
    step(0, 0, 0, 0, 1);
    check("mfhi_release", 32'(ctl), 32'(C_IDLE));
    check("mfhi_cnt", 32'(stall_cnt), 32'd7);

    // Branch beats load-use stall; load-use alone stalls.
    do_reset();
    step(1, 1, 0, 0, 0);
    check("br_over_hz", 32'(ctl), 32'(C_BR));
    step(0, 1, 1, 0, 0);
    check("br_blocks_issue", 32'(ctl), 32'(C_BR));
    step(0, 0, 0, 0, 0);
    check("br_cnt", 32'(stall_cnt), 32'd0);
    step(1, 0, 0, 0, 0);
    check("hz_alone", 32'(ctl), 32'(C_HZ));
    step(1, 0, 1, 0, 0);
    check("hz_blocks_issue", 32'(ctl), 32'(C_HZ));
    step(0, 0, 0, 0, 0);
    check("hz_cnt", 32'(stall_cnt), 32'd2);

    // Back-to-back mults; then a branch during MD_WAIT does not cancel the op.
    do_reset();
    step(0, 0, 1, 0, 0);
    check("b2b_go1", 32'(ctl), 32'(C_GO));
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, 0, 0);
      check($sformatf("b2b_stall%0d", i), 32'(ctl), 32'(i == 3 ? C_SDONE : C_SSTALL));
    end
    step(0, 0, 1, 0, 0);
    check("b2b_go2", 32'(ctl), 32'(C_GO));
    step(0, 1, 1, 0, 1);
    check("b2b_br_busy", 32'(ctl), 32'(C_BR_BUSY));
    step(0, 0, 0, 0, 0);
    check("b2b_busy", 32'(ctl), 32'(C_BUSY));
    step(0, 0, 0, 0, 0);
    check("b2b_done2", 32'(ctl), 32'(C_DONE));
    step(0, 0, 0, 0, 0);
    check("b2b_cnt", 32'(stall_cnt), 32'd3);

    // Saturation of the 4-bit stall counter.
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0, 0, 0);
      if (i == 11) check("sat_mid", 32'(stall_cnt), 32'd10);
    end
    step(0, 0, 0, 0, 0);
    check("sat_top", 32'(stall_cnt), 32'd15);
    step(0, 0, 0, 0, 0);
    check("sat_hold", 32'(stall_cnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
